// File: rtl/wallace_six_bit_multiplier.sv
// wallace_six_bit_multiplier: exact unsigned 6x6 Wallace-tree multiplier with registered 13-bit product (optional input stage: WALLACE_IN_REG_EN)
module ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module wallace_six_bit_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [5:0]  in1,
  input  logic [5:0]  in2,
  output logic [12:0] out,
  output logic        out_valid
);
  logic [5:0] a, b;
  logic v;
`ifdef WALLACE_IN_REG_EN
  // input stage: the tree sees registered operands, adding one cycle of latency
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      v <= 1'b0;
    end else begin
      a <= in1;
      b <= in2;
      v <= in_valid;
    end
`else
  assign a = in1;
  assign b = in2;
  assign v = in_valid;
`endif
  // p[i][j] = in1[j] & in2[i], weight 2^(i+j)
  logic [5:0] p [6];
  for (genvar i = 0; i < 6; i++) begin : g_pp
    assign p[i] = a & {6{b[i]}};
  end
  // stage A: column heights 1,2,3,4,5,6,5,4,3,2,1 -> at most 4
  logic sa4, ca4, sa5f, ca5f, sa5h, ca5h, sa6f, ca6f, sa6h, ca6h, sa7, ca7;
  ha u_a4  (.a(p[0][4]), .b(p[1][3]), .s(sa4), .c(ca4));
  fa u_a5f (.a(p[0][5]), .b(p[1][4]), .ci(p[2][3]), .s(sa5f), .co(ca5f));
  ha u_a5h (.a(p[3][2]), .b(p[4][1]), .s(sa5h), .c(ca5h));
  fa u_a6f (.a(p[1][5]), .b(p[2][4]), .ci(p[3][3]), .s(sa6f), .co(ca6f));
  ha u_a6h (.a(p[4][2]), .b(p[5][1]), .s(sa6h), .c(ca6h));
  fa u_a7  (.a(p[2][5]), .b(p[3][4]), .ci(p[4][3]), .s(sa7), .co(ca7));
  // stage B: at most 3 bits per column
  logic sb3, cb3, sb4, cb4, sb5, cb5, sb6, cb6, sb7, cb7, sb8, cb8;
  ha u_b3 (.a(p[0][3]), .b(p[1][2]), .s(sb3), .c(cb3));
  fa u_b4 (.a(sa4), .b(p[2][2]), .ci(p[3][1]), .s(sb4), .co(cb4));
  fa u_b5 (.a(sa5f), .b(sa5h), .ci(p[5][0]), .s(sb5), .co(cb5));
  fa u_b6 (.a(sa6f), .b(sa6h), .ci(ca5f), .s(sb6), .co(cb6));
  fa u_b7 (.a(sa7), .b(p[5][2]), .ci(ca6f), .s(sb7), .co(cb7));
  fa u_b8 (.a(p[3][5]), .b(p[4][4]), .ci(p[5][3]), .s(sb8), .co(cb8));
  // stage C: at most 2 bits per column, nothing spills past column 10
  logic sc2, cc2, sc3, cc3, sc4, cc4, sc5, cc5, sc6, cc6, sc7, cc7, sc8, cc8, sc9, cc9;
  ha u_c2 (.a(p[0][2]), .b(p[1][1]), .s(sc2), .c(cc2));
  fa u_c3 (.a(sb3), .b(p[2][1]), .ci(p[3][0]), .s(sc3), .co(cc3));
  fa u_c4 (.a(sb4), .b(p[4][0]), .ci(cb3), .s(sc4), .co(cc4));
  fa u_c5 (.a(sb5), .b(ca4), .ci(cb4), .s(sc5), .co(cc5));
  fa u_c6 (.a(sb6), .b(ca5h), .ci(cb5), .s(sc6), .co(cc6));
  fa u_c7 (.a(sb7), .b(ca6h), .ci(cb6), .s(sc7), .co(cc7));
  fa u_c8 (.a(sb8), .b(ca7), .ci(cb7), .s(sc8), .co(cc8));
  fa u_c9 (.a(p[4][5]), .b(p[5][4]), .ci(cb8), .s(sc9), .co(cc9));
  // final two rows and ripple adder over columns 0..10; its carry-out is bit 11
  logic [10:0] ra, rb, sum;
  logic [11:0] cy;
  assign ra = {p[5][5], sc9, sc8, sc7, sc6, sc5, sc4, sc3, sc2, p[0][1], p[0][0]};
  assign rb = {cc9, cc8, cc7, cc6, cc5, cc4, cc3, cc2, p[2][0], p[1][0], 1'b0};
  assign cy[0] = 1'b0;
  for (genvar k = 0; k < 11; k++) begin : g_cpa
    fa u_fa (.a(ra[k]), .b(rb[k]), .ci(cy[k]), .s(sum[k]), .co(cy[k+1]));
  end
  // product register: loads only on valid operands, valid flag tracks every cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v;
      if (v) out <= {1'b0, cy[11], sum};
    end
endmodule

// File: tb/tb_wallace_six_bit_multiplier.sv
// tb_wallace_six_bit_multiplier: directed and exhaustive checks of the Wallace multiplier in either build
module tb_wallace_six_bit_multiplier;
`ifdef WALLACE_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int N = 11;
  logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0;
  logic [5:0] in1 = '0, in2 = '0;
  logic [12:0] out;
  logic out_valid;
  int n_pass = 0, n_total = 0;
  logic        tv_v [N] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [5:0]  tv_a [N] = '{6'd51, 6'd0, 6'd1, 6'd63, 6'd63, 6'd5, 6'd32, 6'd63, 6'd9, 6'd21, 6'd21};
  logic [5:0]  tv_b [N] = '{6'd56, 6'd63, 6'd63, 6'd1, 6'd63, 6'd7, 6'd32, 6'd2, 6'd9, 6'd3, 6'd3};
  logic [12:0] tv_o [N] = '{13'd2856, 13'd0, 13'd63, 13'd63, 13'd3969, 13'd35, 13'd1024, 13'd126, 13'd126, 13'd126, 13'd63};
  logic [12:0] exp_q [$];

  wallace_six_bit_multiplier dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in1(in1), .in2(in2),
    .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic apply(input logic v, input logic [5:0] a, input logic [5:0] b);
    in_valid = v;
    in1 = a;
    in2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [12:0] eo, input logic ev);
    n_total++;
    assert (out === eo && out_valid === ev) n_pass++;
    else $error("FAIL %s: out=%0d out_valid=%b, expected out=%0d out_valid=%b", tag, out, out_valid, eo, ev);
  endtask

  initial begin
    in_valid = 1'b1;
    in1 = 6'd51;
    in2 = 6'd56;
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 13'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("rst_hold", 13'd0, 1'b0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < N + LAT - 1; k++) begin
      if (k < N) apply(tv_v[k], tv_a[k], tv_b[k]);
      else apply(1'b0, 6'd0, 6'd0);
      if (k >= LAT - 1) chk($sformatf("vec%0d", k - LAT + 1), tv_o[k - LAT + 1], tv_v[k - LAT + 1]);
    end
    for (int a = 0; a < 64; a++)
      for (int b = 0; b < 64; b++) begin
        apply(1'b1, 6'(a), 6'(b));
        exp_q.push_back(13'(a * b));
        if (exp_q.size() == LAT) chk($sformatf("exh_%0dx%0d", a, b), exp_q.pop_front(), 1'b1);
      end
    while (exp_q.size() > 0) begin
      apply(1'b0, 6'd0, 6'd0);
      chk("exh_flush", exp_q.pop_front(), 1'b1);
    end
    apply(1'b0, 6'd0, 6'd0);
    chk("idle_hold", 13'd3969, 1'b0);
    apply(1'b1, 6'd63, 6'd63);
    #3 rst_n = 1'b0;
    #1 chk("mid_rst_clear", 13'd0, 1'b0);
    apply(1'b0, 6'd0, 6'd0);
    chk("mid_rst_hold", 13'd0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 6'd0, 6'd0);
      chk("post_rst_quiet", 13'd0, 1'b0);
    end
    apply(1'b1, 6'd7, 6'd9);
    for (int i = 1; i < LAT; i++) apply(1'b0, 6'd0, 6'd0);
    chk("post_rst_new", 13'd63, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/wallace_six_bit_multiplier.md
Name: wallace_six_bit_multiplier

Overview:
- Unsigned 6x6 multiplier built as a Wallace-tree partial-product reducer with a final carry-propagate adder and a registered 13-bit product.
- Used as the exact baseline datapath block that the approximate-multiplier variants are compared against.
- One clock; result is registered, with a valid flag tracking each accepted operand pair.

Parameters:
- None. Widths are fixed: operands 6 bits, product 13 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands on in1/in2 are valid this cycle
- in1  input  6  unsigned multiplicand
- in2  input  6  unsigned multiplier
- out  output  13  registered unsigned product in1*in2
- out_valid  output  1  out holds a new product this cycle

Behaviour:
- Reset: reset is asynchronous and active-low (rst_n) on the single clock clk. While rst_n=0: out=13'd0 and out_valid=0, both immediately and regardless of clk. Both are released on the first rising edge after rst_n deasserts.
- Partial products: pp[i][j] = in1[j] & in2[i] for i,j in 0..5, giving 36 bits. pp[i][j] carries weight 2^(i+j).
- Reduction: reduce the columns with half adders and full adders in Wallace stages (3:2 compression per stage) until every column holds at most 2 bits. Columns 0..10 are used.
- Final add: a 2-row carry-propagate (ripple) adder. Its carry-out feeds bit 11.
- HA and FA are separate leaf modules, instantiated structurally.
- Arithmetic:
  - out = in1*in2, exact and unsigned; maximum is 63*63 = 3969.
  - out[12] is always 0. The port is 13 bits for interface compatibility.
- Latency:
  - Default build: 1 cycle. On each rising edge with in_valid=1, out <= product of the current in1/in2 and out_valid <= 1.
  - When in_valid=0 at the edge, out holds its previous value and out_valid <= 0.
- Throughput: one new operand pair accepted per cycle. No backpressure and no stall input.
- X-safety: out_valid must never go X after reset. out may only change on an edge where in_valid=1.
- Reset mid-operation: a product in flight is discarded. out returns to 0 and out_valid to 0, and no stale result appears after release.

Optional Feature:
- Macro: WALLACE_IN_REG_EN
- Defined:
  - Adds an input register stage on in1, in2 and in_valid, clocked by clk and reset by rst_n to 0.
  - The tree then computes from the registered operands, so total latency is 2 cycles and out_valid follows in_valid by 2 cycles.
- Undefined:
  - Latency is 1 cycle as described above.
- Arithmetic results are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with in1=51, in2=56, in_valid=1 and toggle clk -> out=0, out_valid=0 throughout. Assert rst_n low asynchronously mid-cycle -> outputs clear immediately.
- Directed: in1=6'b110011 (51), in2=6'b111000 (56), in_valid=1 -> after latency, out=13'd2856 (13'b0101100101000) and out_valid=1.
- Corners:
  - 0*63 -> 0
  - 1*63 -> 63
  - 63*1 -> 63
  - 63*63 -> 3969 (13'b0111110000001); out[12]=0 in every case.
- Streaming: back-to-back in_valid pairs (5,7), (32,32), (63,2) -> out = 35, 1024, 126 on consecutive cycles with out_valid=1. A bubble with in_valid=0 -> out_valid=0 and out held.
- Exhaustive: all 4096 operand pairs, compared against a behavioural in1*in2 at the correct latency. Run in both builds, with and without WALLACE_IN_REG_EN.
- Reset mid-stream: drop rst_n while a product is in flight, then release -> no result appears until a new in_valid pair, which returns its correct product.
